fetch_unit: RTL and testbench
=============================

# fetch_unit

Program-counter and fetch sequencer for the 9-bit-instruction core. It sits directly upstream of the control decoder: it drives `ProgCtr` into the instruction ROM, and the ROM's combinational output feeds the decoder. It consumes the decoder's `Jump`, `BranchEn` and `Ack` outputs plus the jump-LUT target. It also owns the start/done handshake with the test harness and a saturating cycle counter for performance reporting.

## Interface
- `PC_W`, default 10: program counter width (ROM depth 2^PC_W).
- `CNT_W`, default 16: cycle counter width.
- `Clk` in 1: sole clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-low. While low at a rising edge, all state returns to reset values.
- `Start` in 1: level from the harness. High means arm/reload; a high-to-low transition launches the program.
- `StartAddr` in PC_W: first instruction address, sampled every ARM cycle.
- `Jump` in 1: unconditional redirect, from the decoder.
- `BranchEn` in 1: taken branch, from the decoder (already qualified with the zero flag).
- `Ack` in 1: halt instruction decoded, from the decoder.
- `Target` in PC_W: redirect address from the jump LUT.
- `ProgCtr` out PC_W: registered PC, addresses the instruction ROM.
- `InstrValid` out 1: high only in RUN; the ROM word at `ProgCtr` is being executed this cycle.
- `Done` out 1: high only in HALT.
- `Overrun` out 1: sticky flag; PC wrapped past 2^PC_W-1 via sequential increment.
- `CycleCount` out CNT_W: number of RUN cycles since the last launch, saturating.

## Operation
- FSM states: IDLE, ARM, RUN, HALT. Reset state is IDLE.
- **IDLE**
  - If `Start`=1, go to ARM.
  - `ProgCtr` holds 0.
- **ARM**
  - Each cycle: `ProgCtr` <= `StartAddr`, `CycleCount` <= 0, `Overrun` <= 0.
  - If `Start`=0, go to RUN.
  - The ARM-to-RUN edge also loads `StartAddr`, so the first RUN cycle executes `StartAddr`.
- **RUN**: the next PC is chosen by priority:
  1. `Ack`=1: go to HALT; `ProgCtr` holds (stays on the halt instruction).
  2. `BranchEn` or `Jump`: `ProgCtr` <= `Target`.
  3. Otherwise: `ProgCtr` <= `ProgCtr`+1, modulo 2^PC_W. On the wrap from all-ones to 0, set `Overrun`.
- **RUN, other rules**
  - `CycleCount` increments every RUN cycle, including the `Ack` cycle, and saturates at 2^CNT_W-1.
  - `Start`=1 has highest priority (above `Ack`): go to ARM and abandon the program.
- **HALT**
  - `ProgCtr`, `CycleCount` and `Overrun` hold.
  - If `Start`=1, go to ARM; otherwise stay.
- **Decoder inputs outside RUN** (`Jump`, `BranchEn`, `Ack`): ignored.
- **`Overrun` on redirect**: a `Target` equal to 0 does not set `Overrun`.
- **Reset values**
  - State = IDLE.
  - `ProgCtr`, `CycleCount` = 0.
  - `InstrValid`, `Done`, `Overrun` = 0.
- **Reset low mid-RUN or mid-HALT**: return to IDLE on that edge; counters are cleared.

## Timing
- **Registers vs. decodes**
  - `ProgCtr`, `CycleCount`, `Overrun` and the state are registers.
  - `InstrValid` and `Done` are pure decodes of the state register; there is no combinational path from inputs to outputs.
- **Single-cycle loop**: `ProgCtr` to ROM to decoder to `Jump`/`BranchEn`/`Ack`/`Target` to next-PC mux must all settle within one clock.
- **Redirect latency**: a redirect decoded in cycle n makes `ProgCtr`=`Target` in cycle n+1. There is no delay slot and no bubble.
- **Launch latency**: `Start` is sampled low at edge k, so `InstrValid`=1 and `ProgCtr`=`StartAddr` from edge k onward.
- **Halt latency**: `Ack` is seen in cycle n, so `Done`=1 from edge n+1.
- **Minimum ARM dwell**: one cycle. `Start` may pulse high for a single edge.

## Structure
- Package `Definitions` gains:
  - enum `fetch_state_t` {IDLE, ARM, RUN, HALT};
  - localparam `PC_W`=10 shared with the instruction ROM and the jump LUT.
- One sub-module is natural: `sat_counter` (parameterised width; clear and enable inputs; saturating) for `CycleCount`.
- The next-PC mux stays inline.

## Test plan
- **Launch**: reset, `Start` 1 for 2 cycles with `StartAddr`=0x005, then 0, with no redirects.
  - `ProgCtr` must read 0x005, 0x006, 0x007 in successive cycles and `InstrValid`=1.
- **Branch**: in RUN at PC 0x010, assert `BranchEn`=1 with `Target`=0x3F0 for one cycle.
  - Next PC is 0x3F0, then 0x3F1.
  - Repeat with `Jump` and an identical result.
- **Halt**: `Ack`=1 at PC 0x020 after 7 RUN cycles (`Ack` cycle included).
  - `Done`=1 next cycle, `ProgCtr` holds 0x020, `CycleCount`=7, and a further `BranchEn` is ignored.
- **Wrap**: `StartAddr`=0x3FE with no redirects.
  - PC sequence is 0x3FE, 0x3FF, 0x000; `Overrun` rises with PC=0x000.
  - A following ARM cycle clears `Overrun`.
- **Abort/reset**:
  - `Start`=1 mid-RUN gives ARM next cycle (`InstrValid`=0, `CycleCount`=0).
  - Separately, `Reset`=0 mid-HALT gives IDLE with all outputs zero.
  - `Ack` together with `Start`=1 in the same cycle goes to ARM, not HALT.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer, instruction ROM and jump LUT.
package Definitions;

    localparam int PC_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer: start/done handshake, next-PC mux, cycle counter.
//   state | meaning
//   IDLE  | after reset, waiting for Start
//   ARM   | Start high: PC tracks StartAddr, counter and Overrun cleared
//   RUN   | executing the ROM word at ProgCtr
//   HALT  | halt decoded, PC and counter frozen until the next Start
module fetch_unit #(
    parameter int PC_W  = Definitions::PC_W,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Jump,
    input  logic             BranchEn,
    input  logic             Ack,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             InstrValid,
    output logic             Done,
    output logic             Overrun,
    output logic [CNT_W-1:0] CycleCount
);

    import Definitions::*;

    fetch_state_t    state;
    fetch_state_t    state_next;
    logic [PC_W-1:0] pc_next;
    logic            overrun_next;
    logic            cnt_clr;
    logic            cnt_en;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Overrun <= 1'b0;
        end else begin
            state   <= state_next;
            ProgCtr <= pc_next;
            Overrun <= overrun_next;
        end
    end

    // Start in RUN outranks Ack, so an abort never lands in HALT.
    always_comb begin
        state_next   = state;
        pc_next      = ProgCtr;
        overrun_next = Overrun;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        case (state)
            IDLE: begin
                if (Start) state_next = ARM;
            end
            ARM: begin
                pc_next      = StartAddr;
                overrun_next = 1'b0;
                cnt_clr      = 1'b1;
                if (!Start) state_next = RUN;
            end
            RUN: begin
                if (Start) begin
                    state_next = ARM;
                    cnt_clr    = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                    if (Ack) begin
                        state_next = HALT;
                    end else if (BranchEn || Jump) begin
                        pc_next = Target;
                    end else begin
                        pc_next = ProgCtr + 1'b1;
                        if (&ProgCtr) overrun_next = 1'b1;
                    end
                end
            end
            HALT: begin
                if (Start) state_next = ARM;
            end
            default: state_next = IDLE;
        endcase
    end

    assign InstrValid = (state == RUN);
    assign Done       = (state == HALT);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (Clk),
        .rst_b (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (CycleCount)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a behavioural model.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int CNT_W   = 16;
    localparam int SMALL_W = 4;
    localparam int PC_MOD  = 1 << PC_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int SML_MAX = (1 << SMALL_W) - 1;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    logic Start = 1'b0;
    logic Jump = 1'b0;
    logic BranchEn = 1'b0;
    logic Ack = 1'b0;
    logic [PC_W-1:0] StartAddr = '0;
    logic [PC_W-1:0] Target = '0;

    logic [PC_W-1:0]    ProgCtr, s_pc;
    logic               InstrValid, Done, Overrun, s_iv, s_done, s_ovr;
    logic [CNT_W-1:0]   CycleCount;
    logic [SMALL_W-1:0] s_cnt;

    int checks = 0;
    int failures = 0;

    // behavioural model: mode as text-like codes, plain integer PC and count
    localparam int M_IDLE = 0, M_ARMING = 1, M_RUNNING = 2, M_HALTED = 3;
    int m_mode = M_IDLE;
    int m_pc = 0;
    int m_cnt = 0;
    bit m_ovr = 1'b0;

    fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Jump(Jump), .BranchEn(BranchEn), .Ack(Ack), .Target(Target),
        .ProgCtr(ProgCtr), .InstrValid(InstrValid), .Done(Done),
        .Overrun(Overrun), .CycleCount(CycleCount)
    );

    fetch_unit #(.PC_W(PC_W), .CNT_W(SMALL_W)) dut_small (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Jump(Jump), .BranchEn(BranchEn), .Ack(Ack), .Target(Target),
        .ProgCtr(s_pc), .InstrValid(s_iv), .Done(s_done),
        .Overrun(s_ovr), .CycleCount(s_cnt)
    );

    always #5 Clk = ~Clk;

    function automatic void model_step();
        if (!Reset) begin
            m_mode = M_IDLE; m_pc = 0; m_cnt = 0; m_ovr = 1'b0;
            return;
        end
        case (m_mode)
            M_IDLE:    if (Start) m_mode = M_ARMING;
            M_ARMING: begin
                m_pc = int'(StartAddr); m_cnt = 0; m_ovr = 1'b0;
                if (!Start) m_mode = M_RUNNING;
            end
            M_RUNNING: begin
                if (Start) begin
                    m_mode = M_ARMING; m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                    if (Ack) m_mode = M_HALTED;
                    else if (BranchEn || Jump) m_pc = int'(Target);
                    else begin
                        if (m_pc + 1 >= PC_MOD) m_ovr = 1'b1;
                        m_pc = (m_pc + 1) % PC_MOD;
                    end
                end
            end
            default:   if (Start) m_mode = M_ARMING;
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0; Start = 1'b0; Jump = 1'b0; BranchEn = 1'b0; Ack = 1'b0;
        tick();
        Reset = 1'b1;
    endtask

    task automatic launch(input logic [PC_W-1:0] addr);
        StartAddr = addr;
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        Reset = 1'b0; Start = 1'b1;
        tick();
        checks++;
        if ({ProgCtr, InstrValid, Done, Overrun, CycleCount} !== '0) begin
            failures++;
            $display("FAIL reset_state: pc=%h iv=%b done=%b ovr=%b cnt=%0d, required all zero",
                     ProgCtr, InstrValid, Done, Overrun, CycleCount);
        end
        Start = 1'b0;
        Reset = 1'b1;
    endtask

    task automatic test_launch();
        do_reset();
        launch(10'h005);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ProgCtr !== PC_W'(10'h005 + i) || InstrValid !== 1'b1) begin
                failures++;
                $display("FAIL launch_seq[%0d]: pc=%h iv=%b, required pc=%h iv=1",
                         i, ProgCtr, InstrValid, 10'h005 + i);
            end
            tick();
        end
    endtask

    task automatic test_branch();
        for (int kind = 0; kind < 2; kind++) begin
            do_reset();
            launch(10'h00C);
            repeat (4) tick();
            checks++;
            if (ProgCtr !== 10'h010) begin
                failures++;
                $display("FAIL redirect_setup[%0d]: pc=%h, required 010", kind, ProgCtr);
            end
            Target = 10'h3F0;
            if (kind == 0) BranchEn = 1'b1; else Jump = 1'b1;
            tick();
            BranchEn = 1'b0; Jump = 1'b0; Target = 10'h155;
            checks++;
            if (ProgCtr !== 10'h3F0 || Overrun !== 1'b0) begin
                failures++;
                $display("FAIL redirect_target[%0d]: pc=%h ovr=%b, required pc=3f0 ovr=0",
                         kind, ProgCtr, Overrun);
            end
            tick();
            checks++;
            if (ProgCtr !== 10'h3F1) begin
                failures++;
                $display("FAIL redirect_next[%0d]: pc=%h, required 3f1", kind, ProgCtr);
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        launch(10'h01A);
        repeat (6) tick();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        checks++;
        if (Done !== 1'b1 || InstrValid !== 1'b0 || ProgCtr !== 10'h020 || CycleCount !== 16'd7) begin
            failures++;
            $display("FAIL halt_entry: done=%b iv=%b pc=%h cnt=%0d, required done=1 iv=0 pc=020 cnt=7",
                     Done, InstrValid, ProgCtr, CycleCount);
        end
        BranchEn = 1'b1; Jump = 1'b1; Target = 10'h100;
        repeat (2) tick();
        BranchEn = 1'b0; Jump = 1'b0;
        checks++;
        if (Done !== 1'b1 || ProgCtr !== 10'h020 || CycleCount !== 16'd7) begin
            failures++;
            $display("FAIL halt_hold: done=%b pc=%h cnt=%0d, required done=1 pc=020 cnt=7",
                     Done, ProgCtr, CycleCount);
        end
    endtask

    task automatic test_wrap();
        logic [PC_W-1:0] exp_pc [3];
        logic            exp_ovr [3];
        exp_pc[0] = 10'h3FE; exp_pc[1] = 10'h3FF; exp_pc[2] = 10'h000;
        exp_ovr[0] = 1'b0;   exp_ovr[1] = 1'b0;   exp_ovr[2] = 1'b1;
        do_reset();
        launch(10'h3FE);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ProgCtr !== exp_pc[i] || Overrun !== exp_ovr[i]) begin
                failures++;
                $display("FAIL wrap_seq[%0d]: pc=%h ovr=%b, required pc=%h ovr=%b",
                         i, ProgCtr, Overrun, exp_pc[i], exp_ovr[i]);
            end
            if (i < 2) tick();
        end
        Start = 1'b1;
        StartAddr = 10'h200;
        repeat (2) tick();
        Start = 1'b0;
        checks++;
        if (Overrun !== 1'b0 || InstrValid !== 1'b0 || ProgCtr !== 10'h200) begin
            failures++;
            $display("FAIL wrap_clear: ovr=%b iv=%b pc=%h, required ovr=0 iv=0 pc=200",
                     Overrun, InstrValid, ProgCtr);
        end
    endtask

    task automatic test_abort();
        do_reset();
        launch(10'h040);
        repeat (3) tick();
        Start = 1'b1;
        tick();
        checks++;
        if (InstrValid !== 1'b0 || CycleCount !== 16'd0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL abort_run: iv=%b cnt=%0d done=%b, required iv=0 cnt=0 done=0",
                     InstrValid, CycleCount, Done);
        end
        Start = 1'b0;
        tick();
        checks++;
        if (InstrValid !== 1'b1 || ProgCtr !== 10'h040) begin
            failures++;
            $display("FAIL abort_relaunch: iv=%b pc=%h, required iv=1 pc=040", InstrValid, ProgCtr);
        end
    endtask

    task automatic test_reset_mid_halt();
        do_reset();
        launch(10'h080);
        repeat (2) tick();
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        checks++;
        if ({ProgCtr, InstrValid, Done, Overrun, CycleCount} !== '0) begin
            failures++;
            $display("FAIL reset_mid_halt: pc=%h iv=%b done=%b ovr=%b cnt=%0d, required all zero",
                     ProgCtr, InstrValid, Done, Overrun, CycleCount);
        end
    endtask

    task automatic test_ack_with_start();
        do_reset();
        launch(10'h090);
        tick();
        Ack = 1'b1; Start = 1'b1;
        tick();
        Ack = 1'b0;
        checks++;
        if (Done !== 1'b0 || InstrValid !== 1'b0 || CycleCount !== 16'd0) begin
            failures++;
            $display("FAIL ack_with_start: done=%b iv=%b cnt=%0d, required done=0 iv=0 cnt=0",
                     Done, InstrValid, CycleCount);
        end
        Start = 1'b0;
        tick();
        checks++;
        if (InstrValid !== 1'b1 || ProgCtr !== 10'h090) begin
            failures++;
            $display("FAIL ack_start_relaunch: iv=%b pc=%h, required iv=1 pc=090", InstrValid, ProgCtr);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        launch(10'h000);
        repeat (20) tick();
        checks++;
        if (CycleCount !== 16'd20 || s_cnt !== 4'(SML_MAX) || ProgCtr !== 10'd20) begin
            failures++;
            $display("FAIL saturate: cnt=%0d small=%0d pc=%h, required cnt=20 small=%0d pc=014",
                     CycleCount, s_cnt, ProgCtr, SML_MAX);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            Reset     = ($urandom_range(0, 99) != 0);
            Start     = ($urandom_range(0, 19) == 0);
            Ack       = ($urandom_range(0, 29) == 0);
            BranchEn  = ($urandom_range(0, 7) == 0);
            Jump      = ($urandom_range(0, 9) == 0);
            Target    = ($urandom_range(0, 3) == 0) ? '0 : PC_W'($urandom);
            StartAddr = ($urandom_range(0, 1) == 0) ? PC_W'(PC_MOD - 1 - $urandom_range(0, 6))
                                                    : PC_W'($urandom);
            tick();
            checks++;
            if (ProgCtr !== PC_W'(m_pc) || InstrValid !== (m_mode == M_RUNNING) ||
                Done !== (m_mode == M_HALTED) || Overrun !== m_ovr ||
                CycleCount !== CNT_W'(m_cnt) ||
                s_cnt !== SMALL_W'((m_cnt < SML_MAX) ? m_cnt : SML_MAX)) begin
                failures++;
                bad++;
                if (bad <= 5)
                    $display("FAIL random[%0d]: pc=%h iv=%b done=%b ovr=%b cnt=%0d small=%0d, required pc=%h mode=%0d ovr=%b cnt=%0d",
                             n, ProgCtr, InstrValid, Done, Overrun, CycleCount, s_cnt,
                             m_pc, m_mode, m_ovr, m_cnt);
            end
        end
        Reset = 1'b1; Start = 1'b0; Ack = 1'b0; BranchEn = 1'b0; Jump = 1'b0;
    endtask

    initial begin
        test_reset();
        test_launch();
        test_branch();
        test_halt();
        test_wrap();
        test_abort();
        test_reset_mid_halt();
        test_ack_with_start();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
